// File: rtl/servo_pulse_decoder.sv
// Measures RC-servo pulse width and rise-to-rise period in microseconds,
// flagging out-of-range pulses and loss of signal.
module servo_pulse_decoder #(
   parameter int CLK_HZ     = 100_000_000,
   parameter int MIN_US     = 500,
   parameter int MAX_US     = 2500,
   parameter int TIMEOUT_US = 25000
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        PULSE_IN,
   output logic [11:0] WIDTH,
   output logic [15:0] PERIOD,
   output logic        VALID,
   output logic        ERR,
   output logic        LOST
);

   localparam int DIV = CLK_HZ / 1_000_000;
   localparam int PW  = $clog2(DIV);
   localparam logic [PW-1:0] PRE_TOP = PW'(DIV - 1);
   localparam logic [11:0]   MIN_W   = 12'(MIN_US);
   localparam logic [11:0]   MAX_W   = 12'(MAX_US);
   localparam logic [15:0]   TMO     = 16'(TIMEOUT_US);

   typedef enum logic [1:0] {
      SYNC_LOW,
      ARMED,
      HIGH,
      WAIT_LOW
   } state_t;

   state_t        state;
   logic          sync1, sync2, prev;
   logic          rise, fall, tick, timeout;
   logic [PW-1:0] pre;
   logic [11:0]   width_cnt, width_nxt;
   logic [15:0]   period_cnt, period_nxt;
   logic [15:0]   pending;
   logic          pend_ok;

   // Next-count values include the tick of the current cycle so that an
   // edge landing on a tick still counts that last microsecond.
   always_comb begin
      rise       = sync2 & ~prev;
      fall       = ~sync2 & prev;
      tick       = (pre == PRE_TOP);
      width_nxt  = width_cnt;
      period_nxt = period_cnt;
      if (tick && prev && width_cnt != 12'hFFF)
         width_nxt = width_cnt + 12'd1;
      if (tick && period_cnt != 16'hFFFF)
         period_nxt = period_cnt + 16'd1;
      timeout    = tick && (period_nxt == TMO);
   end

   // Synchronizer resets high so SYNC_LOW waits for a genuine low level.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         prev  <= 1'b1;
      end else begin
         sync1 <= PULSE_IN;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pre        <= '0;
         width_cnt  <= '0;
         period_cnt <= '0;
      end else if (rise) begin
         pre        <= '0;
         width_cnt  <= '0;
         period_cnt <= '0;
      end else begin
         pre        <= tick ? '0 : pre + 1'b1;
         width_cnt  <= width_nxt;
         period_cnt <= period_nxt;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state   <= SYNC_LOW;
         WIDTH   <= '0;
         PERIOD  <= '0;
         VALID   <= 1'b0;
         ERR     <= 1'b0;
         LOST    <= 1'b1;
         pending <= '0;
         pend_ok <= 1'b0;
      end else begin
         VALID <= 1'b0;
         ERR   <= 1'b0;
         unique case (state)
            SYNC_LOW: begin
               if (!sync2) state <= ARMED;
            end
            ARMED: begin
               if (rise) begin
                  state   <= HIGH;
                  pending <= period_nxt;
                  pend_ok <= ~LOST;
               end
            end
            HIGH: begin
               if (fall) begin
                  state <= ARMED;
                  if (width_nxt >= MIN_W && width_nxt <= MAX_W) begin
                     WIDTH <= width_nxt;
                     if (pend_ok) PERIOD <= pending;
                     VALID <= 1'b1;
                     LOST  <= 1'b0;
                  end else begin
                     ERR <= 1'b1;
                  end
               end else if (width_cnt > MAX_W) begin
                  ERR   <= 1'b1;
                  state <= WAIT_LOW;
               end
            end
            WAIT_LOW: begin
               if (fall) state <= ARMED;
            end
         endcase
         // Loss wins over a same-cycle rise and spoils its period.
         if (timeout) begin
            LOST    <= 1'b1;
            pend_ok <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Scoreboard bench: expected strobes are queued as pulses are driven and
// compared when VALID or ERR fires. Runs with a 2 MHz clock (DIV = 2).
module tb_servo_pulse_decoder;

   localparam int CLK_HZ  = 2_000_000;
   localparam int DIV     = 2;
   localparam int MIN_US  = 50;
   localparam int MAX_US  = 250;
   localparam int TMO_US  = 2500;
   localparam int FRAME   = 2000 * DIV;
   localparam int K_VALID = 0;
   localparam int K_SHORT = 1;
   localparam int K_LONG  = 2;

   typedef struct {
      int kind;
      int w;
      int p;
      int at;
   } exp_t;

   logic        CLK = 0;
   logic        RST_N = 0;
   logic        PULSE_IN = 1;
   logic [11:0] WIDTH;
   logic [15:0] PERIOD;
   logic        VALID, ERR, LOST;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   last_rise = 0;
   logic last_strobe = 0;
   exp_t q[$];

   servo_pulse_decoder #(
      .CLK_HZ(CLK_HZ),
      .MIN_US(MIN_US),
      .MAX_US(MAX_US),
      .TIMEOUT_US(TMO_US)
   ) dut (
      .CLK(CLK),
      .RST_N(RST_N),
      .PULSE_IN(PULSE_IN),
      .WIDTH(WIDTH),
      .PERIOD(PERIOD),
      .VALID(VALID),
      .ERR(ERR),
      .LOST(LOST)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Drives one pulse: hi cycles high then lo cycles low; entered and left
   // just after a falling clock edge.
   task automatic pulse(input int hi, input int lo, input int kind,
                        input int w, input int p);
      exp_t e;
      PULSE_IN  = 1;
      last_rise = cyc;
      if (kind == K_LONG) begin
         e = '{kind, w, p, cyc + 4 + (MAX_US + 1) * DIV};
         q.push_back(e);
      end
      repeat (hi) @(negedge CLK);
      PULSE_IN = 0;
      if (kind == K_VALID || kind == K_SHORT) begin
         e = '{kind, w, p, cyc + 3};
         q.push_back(e);
      end
      repeat (lo) @(negedge CLK);
   endtask

   always @(negedge CLK) begin
      if (RST_N) begin
         if (VALID || ERR) begin
            check("back2back", int'(last_strobe), 0);
            if (q.size() == 0) begin
               check("unexpected_strobe", 1, 0);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("strobe", int'({VALID, ERR}),
                     (e.kind == K_VALID) ? 2 : 1);
               check("width", int'(WIDTH), e.w);
               check("period", int'(PERIOD), e.p);
               check("strobe_cycle", cyc, e.at);
            end
         end
         last_strobe <= VALID | ERR;
      end else begin
         last_strobe <= 0;
      end
   end

   initial begin
      // Reset while the input is already high.
      repeat (5) @(negedge CLK);
      check("rst_width", int'(WIDTH), 0);
      check("rst_period", int'(PERIOD), 0);
      check("rst_valid", int'(VALID), 0);
      check("rst_err", int'(ERR), 0);
      check("rst_lost", int'(LOST), 1);
      RST_N = 1;
      repeat (100 * DIV) @(negedge CLK);
      PULSE_IN = 0;
      repeat (200) @(negedge CLK);

      pulse(150 * DIV, FRAME - 150 * DIV, K_VALID, 150, 0);
      check("lost_cleared", int'(LOST), 0);
      pulse(150 * DIV, FRAME - 150 * DIV, K_VALID, 150, 2000);
      pulse(100 * DIV, FRAME - 100 * DIV, K_VALID, 100, 2000);
      pulse(200 * DIV, FRAME - 200 * DIV, K_VALID, 200, 2000);

      // Rejected pulses hold the last accepted values.
      pulse(30 * DIV, FRAME - 30 * DIV, K_SHORT, 200, 2000);
      pulse(300 * DIV, FRAME - 300 * DIV, K_LONG, 200, 2000);
      pulse(150 * DIV, FRAME - 150 * DIV, K_VALID, 150, 2000);

      // Signal loss after the last rise.
      pulse(150 * DIV, 0, K_VALID, 150, 2000);
      repeat (last_rise + TMO_US * DIV - 5 - cyc) @(negedge CLK);
      check("lost_early", int'(LOST), 0);
      repeat (15) @(negedge CLK);
      check("lost_set", int'(LOST), 1);
      repeat (1000) @(negedge CLK);
      pulse(150 * DIV, FRAME - 150 * DIV, K_VALID, 150, 2000);
      check("lost_recover", int'(LOST), 0);
      pulse(150 * DIV, FRAME - 150 * DIV, K_VALID, 150, 2000);

      // Reset mid-pulse; that pulse must be ignored.
      PULSE_IN = 1;
      repeat (80 * DIV) @(negedge CLK);
      RST_N = 0;
      #1;
      check("midrst_width", int'(WIDTH), 0);
      check("midrst_period", int'(PERIOD), 0);
      check("midrst_lost", int'(LOST), 1);
      check("midrst_valid", int'(VALID), 0);
      @(negedge CLK);
      repeat (3) @(negedge CLK);
      RST_N = 1;
      repeat (70 * DIV - 4) @(negedge CLK);
      PULSE_IN = 0;
      repeat (FRAME) @(negedge CLK);
      pulse(150 * DIV, FRAME - 150 * DIV, K_VALID, 150, 0);
      pulse(150 * DIV, FRAME - 150 * DIV, K_VALID, 150, 2000);

      // Glitch then a normal pulse.
      pulse(5, FRAME - 5, K_SHORT, 150, 2000);
      pulse(175 * DIV, FRAME - 175 * DIV, K_VALID, 175, 2000);

      repeat (50) @(negedge CLK);
      check("queue_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
